// File: rtl/clb_cfg_loader_if.sv
// Byte-wide valid/ready bitstream stream feeding the CLB configuration loader.
// The master drives data/valid; the slave (loader) answers with ready.
interface clb_cfg_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/clb_cfg_loader.sv
// CLB configuration sequencer: assembles 3-byte frames and strobes them into CLB 0..N_CLB-1.
// Optional trailing XOR checksum byte when CFG_CHECKSUM_EN is defined.
module clb_cfg_loader #(
  parameter  int N_CLB   = 16,
  parameter  int FRAME_W = 23,
  localparam int IDX_W   = (N_CLB > 1) ? $clog2(N_CLB) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  clb_cfg_loader_if.slave    bs_i,
  output logic [FRAME_W-1:0] bits_o,
  output logic [N_CLB-1:0]   wr_en_o,
  output logic [IDX_W-1:0]   clb_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_GUARD,
`ifdef CFG_CHECKSUM_EN
    S_CHECK,
    S_ERROR,
`endif
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLB - 1);
  localparam logic [N_CLB-1:0] WR_ONE   = N_CLB'(1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [15:0]          asm_q, asm_d;
  logic [FRAME_W-1:0]   bits_q, bits_d;
  logic [N_CLB-1:0]     wr_en_q, wr_en_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 idle_like;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
  logic                 err_q, err_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      wr_en_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      wr_en_q <= wr_en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CFG_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Partial-frame bytes are pure datapath; they are always rewritten before use.
  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    bits_d  = bits_q;
    wr_en_d = '0;
    done_d  = done_q;
`ifdef CFG_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    accept    = bs_i.valid & ready_q;
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
`ifdef CFG_CHECKSUM_EN
    if (state_q == S_ERROR) idle_like = 1'b1;
`endif

    if (idle_like) begin
      if (start_i) begin
        state_d = S_LOAD;
        idx_d   = '0;
        cnt_d   = '0;
        done_d  = 1'b0;
`ifdef CFG_CHECKSUM_EN
        csum_d  = '0;
        err_d   = 1'b0;
`endif
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
`ifdef CFG_CHECKSUM_EN
            csum_d = csum_q ^ bs_i.data;
`endif
            case (cnt_q)
              2'd0:    asm_d[7:0]  = bs_i.data;
              2'd1:    asm_d[15:8] = bs_i.data;
              default: begin
                // Third byte: drop reserved b2[7], frame goes on the bus with the strobe.
                bits_d  = {bs_i.data[FRAME_W-17:0], asm_q};
                wr_en_d = WR_ONE << idx_q;
                state_d = S_WRITE;
              end
            endcase
            cnt_d = (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
          end
        end
        S_WRITE: state_d = S_GUARD;
        S_GUARD: begin
          if (idx_q == LAST_IDX) begin
`ifdef CFG_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
`ifdef CFG_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            if (bs_i.data == csum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_GUARD);
`ifdef CFG_CHECKSUM_EN
    if (state_d == S_CHECK) begin
      ready_d = 1'b1;
      busy_d  = 1'b1;
    end
`endif
  end

  assign bs_i.ready = ready_q;
  assign bits_o     = bits_q;
  assign wr_en_o    = wr_en_q;
  assign clb_idx_o  = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
`ifdef CFG_CHECKSUM_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader (N_CLB=4): transaction-level model checked every cycle plus
// directed literal expectations for frames, strobe order, reset and restart behaviour.
module tb_clb_cfg_loader;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [22:0] bits;
  logic [N-1:0] wr_en;
  logic [1:0]  idx;
  logic        busy, done, err;

  clb_cfg_loader_if bus ();

  clb_cfg_loader #(.N_CLB(N), .FRAME_W(23)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .bs_i     (bus.slave),
    .bits_o   (bits),
    .wr_en_o  (wr_en),
    .clb_idx_o(idx),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: "act" = a load is running; ph 0 = taking frame bytes, 1 = strobe cycle,
  // 2 = quiet cycle after the strobe, 3 = waiting for checksum byte.
  logic [7:0]  mb [0:3*N-1];
  int          mn, ph, kwr;
  bit          mact, done_m, err_m;
  logic [22:0] bits_m;
  logic [1:0]  idx_m;
  logic [7:0]  csum_m;
  logic [N-1:0] log_wr [0:63];
  logic [22:0] log_bits [0:63];
  int          npulse = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", bus.ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_bits", bits, 0);
      chk("rst_idx", idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      mact = 0; ph = 0; mn = 0; kwr = 0; bits_m = '0;
      done_m = 0; err_m = 0; idx_m = '0; csum_m = '0;
    end else begin
      chk("ready", bus.ready, mact && (ph == 0 || ph == 3));
      chk("busy", busy, mact);
      chk("done", done, done_m);
      chk("err", err, err_m);
      chk("wr_en", wr_en, (ph == 1) ? (32'd1 << kwr) : 32'd0);
      chk("bits", bits, bits_m);
      chk("idx", idx, idx_m);
      if (wr_en != '0 && npulse < 64) begin
        log_wr[npulse]   = wr_en;
        log_bits[npulse] = bits;
        npulse++;
      end
      if (!mact) begin
        if (start) begin
          mact = 1; ph = 0; mn = 0; idx_m = '0;
          done_m = 0; err_m = 0; csum_m = '0;
        end
      end else begin
        case (ph)
          0: if (bus.valid) begin
            mb[mn] = bus.data;
            csum_m ^= bus.data;
            mn++;
            if (mn % 3 == 0) begin
              kwr    = mn / 3 - 1;
              bits_m = {mb[mn-1][6:0], mb[mn-2], mb[mn-3]};
              ph     = 1;
            end
          end
          1: ph = 2;
          2: if (kwr == N - 1) begin
`ifdef CFG_CHECKSUM_EN
            ph = 3;
`else
            mact = 0; done_m = 1; ph = 0;
`endif
          end else begin
            ph = 0;
            idx_m = 2'(kwr + 1);
          end
          default: if (bus.valid) begin
            mact = 0; ph = 0;
            if (bus.data == csum_m) done_m = 1;
            else err_m = 1;
          end
        endcase
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t = 0;
    if (rnd) begin
      for (int i = 0; i < 4 && $urandom_range(1, 0) == 1; i++) begin
        bus.valid = 1'b0;
        bus.data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.valid = 1'b1;
    bus.data  = b;
    while (!bus.ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("byte_timeout", 0, 1);
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, input bit rnd);
    send_byte(b0, rnd);
    send_byte(b1, rnd);
    send_byte(b2, rnd);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!done && !err && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 30) chk("end_timeout", 0, 1);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.valid = 1'b1; bus.data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en_lit", wr_en, 0);
    chk("reset_ready_lit", bus.ready, 0);
    rst_n = 1'b1;
    bus.valid = 1'b0;
    @(posedge clk); #1;

    // Four identical frames, back-to-back bytes
    base = npulse;
    pulse_start();
    for (int k = 0; k < N; k++) send_frame(8'h34, 8'h12, 8'h7F, 1'b0);
`ifdef CFG_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    wait_end();
    chk("t1_npulse", npulse - base, 4);
    for (int k = 0; k < N; k++) begin
      chk("t1_wr_order", log_wr[base+k], 32'd1 << k);
      chk("t1_frame", log_bits[base+k], 23'h7F1234);
    end
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);

    // Random valid gaps, reserved bit set, start pulsed mid-load
    base = npulse;
    pulse_start();
    for (int k = 0; k < N; k++) begin
      send_frame(8'h10 + 8'(k), 8'hC0 + 8'(k), 8'hFF, 1'b1);
      if (k == 1) pulse_start();
    end
`ifdef CFG_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    wait_end();
    chk("t2_npulse", npulse - base, 4);
    chk("t2_frame0", log_bits[base], 23'h7FC010);
    chk("t2_frame3", log_bits[base+3], 23'h7FC313);
    chk("t2_wr3", log_wr[base+3], 4'b1000);
    chk("t2_done", done, 1);

    // Start from DONE clears done; reset lands in the third frame's strobe cycle
    pulse_start();
    chk("t3_done_cleared", done, 0);
    chk("t3_busy", busy, 1);
    send_frame(8'h01, 8'h02, 8'h03, 1'b0);
    send_frame(8'h04, 8'h05, 8'h06, 1'b0);
    send_frame(8'h07, 8'h08, 8'h09, 1'b0);
    chk("t3_wr_before_rst", wr_en, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t3_wr_after_rst", wr_en, 0);
    chk("t3_busy_after_rst", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reload after reset restarts at CLB 0
    base = npulse;
    pulse_start();
    for (int k = 0; k < N; k++) send_frame(8'hAA, 8'h55, 8'h01, 1'b0);
`ifdef CFG_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    wait_end();
    chk("t4_wr0", log_wr[base], 4'b0001);
    chk("t4_frame0", log_bits[base], 23'h0155AA);
    chk("t4_done", done, 1);

`ifdef CFG_CHECKSUM_EN
    // Wrong checksum byte aborts with err
    pulse_start();
    for (int k = 0; k < N; k++) send_frame(8'h34, 8'h12, 8'h7F, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_end();
    chk("t5_err", err, 1);
    chk("t5_done", done, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
